// File: rtl/ddr3_phy_pkg.sv
// Shared definitions for the DDR3 PHY byte-lane delay path: lane delay
// address map, table size, and the sequencer state encoding.
package ddr3_phy_pkg;

    localparam logic [4:0] DLY_DQ_O  = 5'd0;
    localparam logic [4:0] DLY_DQS_O = 5'd8;
    localparam logic [4:0] DLY_DM_O  = 5'd9;
    localparam logic [4:0] DLY_DQ_I  = 5'd16;
    localparam logic [4:0] DLY_DQS_I = 5'd24;

    localparam int         NUM_LANE_DLY = 19;
    localparam logic [4:0] LAST_IDX     = 5'(NUM_LANE_DLY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP,
        ST_SET
    } seq_state_e;

    // Output delays occupy idx 0..9, input delays are packed in after them.
    function automatic logic [4:0] idx_to_addr(input logic [4:0] idx);
        return (idx <= DLY_DM_O) ? idx : idx + (DLY_DQ_I - DLY_DM_O - 5'd1);
    endfunction

    function automatic logic [4:0] addr_to_idx(input logic [4:0] addr);
        return (addr <= DLY_DM_O) ? addr : addr - (DLY_DQ_I - DLY_DM_O - 5'd1);
    endfunction

    function automatic logic addr_valid(input logic [4:0] addr);
        return (addr <= DLY_DM_O) || ((addr >= DLY_DQ_I) && (addr <= DLY_DQS_I));
    endfunction

endpackage

// File: rtl/dly_table_19x8.sv
// Shadow table of the 19 lane delay values with per-entry dirty tracking.
// A host write in the same cycle as a clear keeps the entry dirty.
module dly_table_19x8
    import ddr3_phy_pkg::*;
#(
    parameter logic [7:0] DLY_INIT = 8'h00
) (
    input  logic                             clk_div,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [4:0]                       wr_addr,
    input  logic [7:0]                       wr_data,
    input  logic [4:0]                       rd_addr,
    output logic [7:0]                       rd_data,
    input  logic                             clr_en,
    input  logic [4:0]                       clr_idx,
    output logic [NUM_LANE_DLY-1:0][7:0]     entries,
    output logic [NUM_LANE_DLY-1:0]          dirty
);

    logic       wr_hit;
    logic [4:0] wr_idx;

    assign wr_hit = wr_en && addr_valid(wr_addr);
    assign wr_idx = addr_to_idx(wr_addr);

    always_ff @(posedge clk_div) begin
        if (rst) begin
            entries <= {NUM_LANE_DLY{DLY_INIT}};
            dirty   <= '1;
            rd_data <= 8'h00;
        end else begin
            rd_data <= addr_valid(rd_addr) ? entries[addr_to_idx(rd_addr)] : 8'h00;
            if (clr_en)
                dirty[clr_idx] <= 1'b0;
            // Placed after the clear so a colliding write leaves the entry dirty.
            if (wr_hit) begin
                entries[wr_idx] <= wr_data;
                dirty[wr_idx]   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/byte_lane_dly_seq.sv
// Byte-lane delay sequencer: replays shadow-table entries onto the lane's
// ld_delay load interface, one slot per idx, then issues a single set.
module byte_lane_dly_seq
    import ddr3_phy_pkg::*;
#(
    parameter int         SET_GAP  = 2,
    parameter logic [7:0] DLY_INIT = 8'h00
) (
    input  logic       clk_div,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    input  logic       start,
    input  logic       force_all,
    output logic       busy,
    output logic       done,
    output logic [7:0] dly_data,
    output logic [4:0] dly_addr,
    output logic       ld_delay,
    output logic       set
);

    localparam logic [3:0] GAP_LAST = 4'(SET_GAP - 1);

    seq_state_e                      state;
    logic [4:0]                      idx;
    logic                            force_q;
    logic [3:0]                      gap_cnt;
    logic [NUM_LANE_DLY-1:0][7:0]    entries;
    logic [NUM_LANE_DLY-1:0]         dirty;

    logic [4:0] nidx;
    logic       nfq;
    logic       nhit;
    logic       nld;
    logic [7:0] ndata;

    dly_table_19x8 #(.DLY_INIT(DLY_INIT)) u_table (
        .clk_div (clk_div),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .clr_en  ((state == ST_LOAD) && ld_delay),
        .clr_idx (idx),
        .entries (entries),
        .dirty   (dirty)
    );

    // Next slot's contents; a write landing now is forwarded so it is not missed.
    always_comb begin
        nidx  = ((state == ST_LOAD) && (idx != LAST_IDX)) ? idx + 5'd1 : 5'd0;
        nfq   = (state == ST_IDLE) ? force_all : force_q;
        nhit  = wr_en && addr_valid(wr_addr) && (addr_to_idx(wr_addr) == nidx);
        ndata = nhit ? wr_data : entries[nidx];
        nld   = nfq || nhit || dirty[nidx];
    end

    always_ff @(posedge clk_div) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= 5'd0;
            force_q  <= 1'b0;
            gap_cnt  <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ld_delay <= 1'b0;
            set      <= 1'b0;
            dly_data <= 8'h00;
            dly_addr <= 5'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        idx      <= 5'd0;
                        force_q  <= force_all;
                        busy     <= 1'b1;
                        dly_addr <= idx_to_addr(nidx);
                        dly_data <= ndata;
                        ld_delay <= nld;
                    end
                end
                ST_LOAD: begin
                    if (idx == LAST_IDX) begin
                        ld_delay <= 1'b0;
                        gap_cnt  <= 4'd0;
                        if (SET_GAP == 0) begin
                            state <= ST_SET;
                            set   <= 1'b1;
                        end else begin
                            state <= ST_GAP;
                        end
                    end else begin
                        idx      <= nidx;
                        dly_addr <= idx_to_addr(nidx);
                        dly_data <= ndata;
                        ld_delay <= nld;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + 4'd1;
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_SET;
                        set   <= 1'b1;
                    end
                end
                ST_SET: begin
                    set   <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_lane_dly_seq.sv
// Self-checking bench for byte_lane_dly_seq: address-level reference model
// of the shadow table predicts every load slot, set and done of each pass.
module tb_byte_lane_dly_seq;

    localparam int         SET_GAP  = 2;
    localparam logic [7:0] DLY_INIT = 8'h00;
    localparam int         PASS_LEN = 22 + SET_GAP;

    logic       clk_div = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = 5'd0;
    logic [7:0] wr_data = 8'h00;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_data;
    logic       start = 1'b0;
    logic       force_all = 1'b0;
    logic       busy, done, ld_delay, set;
    logic [7:0] dly_data;
    logic [4:0] dly_addr;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] ref_tbl [32];
    bit         ref_dirty [32];

    // Per-pass schedule: host writes and extra start pulses, as offsets from start.
    int s_off[$], s_addr[$], s_data[$], b_off[$];

    always #5 clk_div = ~clk_div;

    byte_lane_dly_seq #(.SET_GAP(SET_GAP), .DLY_INIT(DLY_INIT)) dut (
        .clk_div   (clk_div),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .start     (start),
        .force_all (force_all),
        .busy      (busy),
        .done      (done),
        .dly_data  (dly_data),
        .dly_addr  (dly_addr),
        .ld_delay  (ld_delay),
        .set       (set)
    );

    function automatic bit m_valid(int a);
        return (a >= 0 && a <= 9) || (a >= 16 && a <= 24);
    endfunction

    function automatic int m_addr(int k);
        return (k < 10) ? k : 16 + (k - 10);
    endfunction

    task automatic step();
        @(posedge clk_div);
        #1;
    endtask

    task automatic model_reset();
        for (int a = 0; a < 32; a++) begin
            ref_tbl[a]   = DLY_INIT;
            ref_dirty[a] = m_valid(a);
        end
    endtask

    task automatic model_write(int a, int d);
        if (m_valid(a)) begin
            ref_tbl[a]   = 8'(d);
            ref_dirty[a] = 1'b1;
        end
    endtask

    task automatic host_write(int a, int d);
        wr_en = 1'b1; wr_addr = 5'(a); wr_data = 8'(d);
        step();
        wr_en = 1'b0;
        model_write(a, d);
    endtask

    task automatic read_check(int a);
        logic [7:0] exp;
        rd_addr = 5'(a);
        step();
        exp = m_valid(a) ? ref_tbl[a] : 8'h00;
        n_chk++;
        if (rd_data !== exp)
            $display("FAIL readback addr=%0d got %h exp %h", a, rd_data, exp);
        else n_pass++;
    endtask

    // Runs one pass with the queued schedule and checks every cycle of it.
    task automatic run_pass(bit fa, string name);
        bit         exp_ld [19];
        logic [7:0] exp_d  [19];
        bit         app [64];
        int         p, k, a;
        for (int j = 0; j < 64; j++) app[j] = 1'b0;
        // A write is visible to slot k if issued at offset <= k (slot k shows at k+1).
        for (int kk = 0; kk < 19; kk++) begin
            for (int j = 0; j < s_off.size(); j++)
                if (!app[j] && s_off[j] <= kk) begin
                    model_write(s_addr[j], s_data[j]);
                    app[j] = 1'b1;
                end
            a = m_addr(kk);
            exp_ld[kk] = fa || ref_dirty[a];
            exp_d[kk]  = ref_tbl[a];
            if (exp_ld[kk]) ref_dirty[a] = 1'b0;
        end
        for (int j = 0; j < s_off.size(); j++)
            if (!app[j]) model_write(s_addr[j], s_data[j]);

        for (int o = 0; o <= PASS_LEN; o++) begin
            wr_en     = 1'b0;
            start     = (o == 0);
            force_all = (o == 0) ? fa : 1'b1;
            for (int j = 0; j < s_off.size(); j++)
                if (s_off[j] == o) begin
                    wr_en = 1'b1; wr_addr = 5'(s_addr[j]); wr_data = 8'(s_data[j]);
                end
            for (int j = 0; j < b_off.size(); j++)
                if (b_off[j] == o) start = 1'b1;
            step();
            p = o + 1;
            n_chk++;
            if (busy !== (p <= 20 + SET_GAP))
                $display("FAIL %s busy p=%0d got %b exp %b", name, p, busy, (p <= 20 + SET_GAP));
            else n_pass++;
            if (p <= 19) begin
                k = p - 1;
                n_chk++;
                if (dly_addr !== 5'(m_addr(k)))
                    $display("FAIL %s dly_addr slot=%0d got %0d exp %0d", name, k, dly_addr, m_addr(k));
                else n_pass++;
                n_chk++;
                if (ld_delay !== exp_ld[k])
                    $display("FAIL %s ld_delay slot=%0d got %b exp %b", name, k, ld_delay, exp_ld[k]);
                else n_pass++;
                if (exp_ld[k]) begin
                    n_chk++;
                    if (dly_data !== exp_d[k])
                        $display("FAIL %s dly_data slot=%0d got %h exp %h", name, k, dly_data, exp_d[k]);
                    else n_pass++;
                end
            end else begin
                n_chk++;
                if (ld_delay !== 1'b0)
                    $display("FAIL %s ld_delay outside load p=%0d got %b exp 0", name, p, ld_delay);
                else n_pass++;
            end
            n_chk++;
            if (set !== (p == 20 + SET_GAP))
                $display("FAIL %s set p=%0d got %b exp %b", name, p, set, (p == 20 + SET_GAP));
            else n_pass++;
            n_chk++;
            if (done !== (p == 21 + SET_GAP))
                $display("FAIL %s done p=%0d got %b exp %b", name, p, done, (p == 21 + SET_GAP));
            else n_pass++;
        end
        start = 1'b0; wr_en = 1'b0; force_all = 1'b0;
        s_off.delete(); s_addr.delete(); s_data.delete(); b_off.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        model_reset();
        n_chk++;
        if ({busy, done, ld_delay, set} !== 4'b0)
            $display("FAIL reset ctrl got %b exp 0000", {busy, done, ld_delay, set});
        else n_pass++;
        n_chk++;
        if ({dly_addr, dly_data} !== 13'd0)
            $display("FAIL reset dly got %h/%h exp 0/0", dly_addr, dly_data);
        else n_pass++;
        n_chk++;
        if (rd_data !== 8'h00)
            $display("FAIL reset rd_data got %h exp 00", rd_data);
        else n_pass++;
    endtask

    task automatic test_power_up();
        run_pass(1'b0, "power_up");
    endtask

    task automatic test_dirty_only();
        host_write(3, 8'h5A);
        host_write(24, 8'hC7);
        run_pass(1'b0, "dirty_only");
        run_pass(1'b0, "clean_pass");
    endtask

    task automatic test_write_during_pass();
        s_off.push_back(2); s_addr.push_back(20); s_data.push_back(8'h11);
        s_off.push_back(5); s_addr.push_back(2);  s_data.push_back(8'h22);
        run_pass(1'b0, "wr_in_pass");
        run_pass(1'b0, "wr_in_pass_next");
    endtask

    task automatic test_collision();
        // Slot for idx 5 is displayed at offset 6; a write then collides with its clear.
        s_off.push_back(6); s_addr.push_back(5); s_data.push_back(int'($urandom_range(255)));
        run_pass(1'b0, "collision");
        run_pass(1'b0, "collision_next");
    endtask

    task automatic test_invalid();
        host_write(12, 8'hFF);
        read_check(12);
        run_pass(1'b0, "invalid_wr");
    endtask

    task automatic test_busy_start();
        b_off.push_back(4);
        b_off.push_back(20 + SET_GAP);
        run_pass(1'b0, "busy_start");
    endtask

    task automatic test_force_all();
        for (int i = 0; i < 4; i++)
            host_write(int'($urandom_range(31)), int'($urandom_range(255)));
        run_pass(1'b1, "force_all");
    endtask

    task automatic test_readback();
        logic [7:0] old;
        for (int a = 0; a < 32; a++) read_check(a);
        old = ref_tbl[9];
        rd_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = ~old;
        step();
        wr_en = 1'b0;
        n_chk++;
        if (rd_data !== old)
            $display("FAIL rd_same_cycle got %h exp %h", rd_data, old);
        else n_pass++;
        model_write(9, int'(~old));
        read_check(9);
    endtask

    task automatic test_random();
        bit fa;
        for (int r = 0; r < 6; r++) begin
            for (int o = 0; o <= PASS_LEN; o++)
                if ($urandom_range(3) == 0) begin
                    s_off.push_back(o);
                    s_addr.push_back(int'($urandom_range(31)));
                    s_data.push_back(int'($urandom_range(255)));
                end
            fa = 1'($urandom_range(1));
            run_pass(fa, "random");
        end
        for (int a = 0; a < 32; a++) read_check(a);
    endtask

    task automatic test_reset_mid_pass();
        int saw;
        start = 1'b1; force_all = 1'b0;
        step();
        start = 1'b0;
        for (int o = 1; o < 8; o++) step();
        // idx 7 is on the load interface now
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        n_chk++;
        if ({busy, done, ld_delay, set, dly_addr, dly_data} !== 17'd0)
            $display("FAIL mid_reset outputs got %b/%b/%b/%b %h/%h exp all 0",
                     busy, done, ld_delay, set, dly_addr, dly_data);
        else n_pass++;
        saw = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (set || busy || ld_delay || done) saw++;
        end
        n_chk++;
        if (saw != 0)
            $display("FAIL mid_reset activity got %0d active cycles exp 0", saw);
        else n_pass++;
        read_check(3);
        run_pass(1'b0, "after_reset");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_power_up();
        test_dirty_only();
        test_write_during_pass();
        test_collision();
        test_invalid();
        test_busy_start();
        test_force_all();
        test_readback();
        test_random();
        test_reset_mid_pass();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
